// File: rtl/sync_rr_arbiter.sv
// rtl/sync_rr_arbiter.sv - four-way round-robin arbiter with synchronized requests and hold limit
// Requests are double-flopped; a three-state FSM grants, limits hold time and forces a recovery gap.
module sync_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [3:0] async_req,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [3:0] sync1_q;
  logic [3:0] sreq_q;
  state_t     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] last_owner_q, last_owner_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] grant_id_q, grant_id_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q <= 4'b0000;
      sreq_q  <= 4'b0000;
    end else begin
      sync1_q <= async_req;
      sreq_q  <= sync1_q;
    end
  end

  // Search starts just after the previous owner, so a revoked requester drops to last place.
  always_comb begin
    winner = 2'd0;
    cand   = 2'd0;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = last_owner_q + 2'd1 + 2'(i);
      if (!found && sreq_q[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    last_owner_d = last_owner_q;
    grant_d      = grant_q;
    grant_id_d   = grant_id_q;
    busy_d       = busy_q;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = GRANT;
          hold_cnt_d   = 8'd0;
          last_owner_d = winner;
          grant_d      = 4'b0001 << winner;
          grant_id_d   = winner;
          busy_d       = 1'b1;
        end
      end
      GRANT: begin
        // Release is tested first so a coincident limit never raises timeout.
        if (!sreq_q[grant_id_q] || (hold_cnt_q == HOLD_LAST)) begin
          state_d    = RECOVER;
          grant_d    = 4'b0000;
          grant_id_d = 2'd0;
          busy_d     = 1'b0;
          timeout_d  = sreq_q[grant_id_q];
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        grant_d    = 4'b0000;
        grant_id_d = 2'd0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      hold_cnt_q   <= 8'd0;
      last_owner_q <= 2'd3;
      grant_q      <= 4'b0000;
      grant_id_q   <= 2'd0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
      grant_q      <= grant_d;
      grant_id_q   <= grant_id_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_sync_rr_arbiter.sv
// tb/tb_sync_rr_arbiter.sv - scoreboard bench for sync_rr_arbiter
// Stimulus queues expected grant episodes; a negedge monitor reconstructs episodes and compares.
module tb_sync_rr_arbiter;

  logic       clk;
  logic       n_rst;
  logic [3:0] async_req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  sync_rr_arbiter #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .async_req (async_req),
    .grant     (grant),
    .grant_id  (grant_id),
    .busy      (busy),
    .timeout   (timeout)
  );

  typedef struct {
    logic [3:0] g;
    logic [1:0] id;
    int         start;
    int         len;
    logic       to;
  } ep_t;

  ep_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  sb_en = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required completion", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: enc = 2'd1;
      4'b0100: enc = 2'd2;
      4'b1000: enc = 2'd3;
      default: enc = 2'd0;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] id, input int start, input int len,
                      input logic to);
    ep_t e;
    e.g = g; e.id = id; e.start = start; e.len = len; e.to = to;
    exp_q.push_back(e);
  endtask

  // Monitor: invariants every cycle, plus one scoreboard comparison per completed grant episode.
  initial begin
    bit         in_ep;
    logic [3:0] ep_g;
    logic [1:0] ep_id;
    int         ep_start;
    int         ep_len;
    logic       prev_to;
    bit         ok;
    ep_t        e;
    in_ep = 1'b0; ep_g = 4'b0; ep_id = 2'd0; ep_start = 0; ep_len = 0; prev_to = 1'b0;
    forever begin
      @(negedge clk);
      ok = !$isunknown({grant, grant_id, busy, timeout}) && $onehot0(grant) &&
           (busy == (grant != 4'b0)) && (grant_id == enc(grant)) &&
           !(timeout && grant != 4'b0) && !(timeout && prev_to) &&
           !(in_ep && grant != 4'b0 && grant != ep_g);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL invariant: got grant=%b id=%0d busy=%b timeout=%b prev_timeout=%b required consistent one-hot outputs",
                 grant, grant_id, busy, timeout, prev_to);
      end
      prev_to = timeout;
      if (!in_ep && grant != 4'b0) begin
        in_ep = 1'b1; ep_g = grant; ep_id = grant_id; ep_start = cyc; ep_len = 1;
      end else if (in_ep && grant != 4'b0) begin
        ep_len++;
      end else if (in_ep) begin
        in_ep = 1'b0;
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_grant: got grant=%b at cycle %0d required no grant", ep_g, ep_start);
          end else begin
            e = exp_q.pop_front();
            check("ep_grant", 32'(ep_g), 32'(e.g));
            check("ep_grant_id", 32'(ep_id), 32'(e.id));
            check("ep_start_cycle", 32'(ep_start), 32'(e.start));
            check("ep_length", 32'(ep_len), 32'(e.len));
            check("ep_timeout", 32'(timeout), 32'(e.to));
          end
        end
      end
    end
  end

  initial begin
    int c0;
    int r;
    n_rst = 1'b0;
    async_req = 4'b1111;
    #1;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_timeout", 32'(timeout), 32'h0);
    check("reset_grant_id", 32'(grant_id), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold_grant", 32'({grant, busy, timeout}), 32'h0);
    end
    async_req = 4'b0000;
    idle(1);
    n_rst = 1'b1;
    idle(4);

    // Single request released after four cycles.
    c0 = cyc;
    async_req = 4'b0100;
    push(4'b0100, 2'd2, c0 + 3, 4, 1'b0);
    idle(4);
    async_req = 4'b0000;
    idle(8);

    // Release lands in the same cycle as the hold limit: no timeout.
    c0 = cyc;
    async_req = 4'b1000;
    push(4'b1000, 2'd3, c0 + 3, 8, 1'b0);
    idle(8);
    async_req = 4'b0000;
    idle(10);

    n_rst = 1'b0;
    idle(2);
    n_rst = 1'b1;
    idle(3);

    // All four requesting: rotation with timeout on every grant.
    c0 = cyc;
    async_req = 4'b1111;
    push(4'b0001, 2'd0, c0 + 3,  8, 1'b1);
    push(4'b0010, 2'd1, c0 + 13, 8, 1'b1);
    push(4'b0100, 2'd2, c0 + 23, 8, 1'b1);
    push(4'b1000, 2'd3, c0 + 33, 8, 1'b1);
    push(4'b0001, 2'd0, c0 + 43, 8, 1'b1);
    idle(49);
    async_req = 4'b0000;
    idle(12);

    // Reset in the middle of a grant, then 0 and 1 compete.
    c0 = cyc;
    async_req = 4'b0010;
    push(4'b0010, 2'd1, c0 + 3, 3, 1'b0);
    idle(5);
    #2;
    n_rst = 1'b0;
    #1;
    check("midreset_grant", 32'(grant), 32'h0);
    check("midreset_busy", 32'(busy), 32'h0);
    async_req = 4'b0011;
    idle(2);
    n_rst = 1'b1;
    r = cyc;
    push(4'b0001, 2'd0, r + 3,  8, 1'b1);
    push(4'b0010, 2'd1, r + 13, 8, 1'b1);
    idle(19);
    async_req = 4'b0000;
    idle(12);

    // Unknown inputs: only the per-cycle invariants apply.
    sb_en = 1'b0;
    async_req = 4'bxxxx;
    idle(100);
    async_req = 4'b0000;
    idle(20);
    check("post_x_idle", 32'({grant, busy, timeout}), 32'h0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_rr_arbiter.md
SYNC_RR_ARBITER -- requirements
Module: sync_rr_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
REQ-002 Parameter MAX_HOLD, default 8, SHALL set the maximum number of consecutive cycles one grant may be held (legal range 2..255).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 async_req  input  4  asynchronous request lines, one per requester; may change at any time relative to clk.
REQ-006 grant  output  4  registered one-hot grant; all-zero when no owner.
REQ-007 grant_id  output  2  registered index of current owner; 0 when grant is all-zero.
REQ-008 busy  output  1  registered; high while any grant bit is high.
REQ-009 timeout  output  1  registered single-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Function
REQ-010 Each async_req bit SHALL pass through its own two-stage flip-flop synchronizer, both stages reset to 0; only the second-stage value (sreq) SHALL be used by control logic.
REQ-011 The control FSM SHALL have exactly three states: IDLE, GRANT, RECOVER.
REQ-012 IDLE: if any sreq bit is high, select a winner by round-robin and enter GRANT at the next edge, with grant, grant_id and busy updated at that same edge; otherwise remain in IDLE.
REQ-013 Round-robin: search order starts at (last_owner+1) mod 4 and wraps. last_owner updates on every GRANT entry.
REQ-014 GRANT: hold_cnt SHALL be cleared on entry and increment by 1 each cycle spent in GRANT.
REQ-015 GRANT exit on owner release: if sreq[owner] is 0, go to RECOVER at next edge. grant clears at that edge. timeout stays 0.
REQ-016 GRANT exit on limit: if sreq[owner] is 1 and hold_cnt equals MAX_HOLD-1, go to RECOVER at next edge. grant clears at that edge. timeout is 1 for exactly that one cycle.
REQ-017 If release and limit coincide, release takes priority and timeout SHALL stay 0.
REQ-018 Requests from non-owners during GRANT SHALL NOT affect the grant.
REQ-019 RECOVER SHALL last exactly one cycle with grant all-zero, then return to IDLE unconditionally.
REQ-020 grant high time SHALL therefore be 1..MAX_HOLD cycles, with at least one idle cycle between any two grants.
REQ-021 Latency: async_req[i] stable high before rising edge N, block in IDLE, no competing request: sreq[i] rises after edge N+1 and grant[i] rises after edge N+2.
REQ-022 Release latency: async_req[owner] falls before edge N: grant falls after edge N+2.
REQ-023 A requester revoked by timeout that keeps requesting SHALL become lowest priority and be regranted only after all other pending requesters are served.
REQ-024 grant SHALL never have more than one bit set; grant, grant_id and busy SHALL be mutually consistent every cycle.
REQ-025 An X on async_req SHALL resolve to 0 or 1 at the synchronizer output. Control outputs SHALL never be X after reset release.

Reset
REQ-026 While n_rst=0, regardless of clk: synchronizer stages=0, state=IDLE, grant=0000, grant_id=0, busy=0, timeout=0, hold_cnt=0, last_owner=3 (requester 0 first priority).
REQ-027 Reset asserted mid-GRANT SHALL clear grant immediately (asynchronously), not at the next edge.
REQ-028 After reset release, the first grant SHALL require the full two-stage synchronization latency of REQ-021.

Verification
REQ-029 Power-on reset: n_rst=0 with async_req=1111 -> grant=0000, busy=0, timeout=0, during reset and across two clocks.
REQ-030 Single request, MAX_HOLD=8: async_req=0100 at negedge, dropped 4 cycles later -> grant=0100, grant_id=2 two edges after the request; grant falls two edges after the drop; timeout never 1.
REQ-031 Round-robin fairness: async_req=1111 held -> grants 0001,0010,0100,1000,0001; each grant lasts 8 cycles; each is followed by a timeout pulse and one idle cycle.
REQ-032 Simultaneous release and limit: owner drops its request so sreq falls in the cycle where hold_cnt=7 -> RECOVER entered, timeout=0.
REQ-033 Reset mid-grant: assert n_rst during GRANT of requester 1 -> grant=0000 before the next edge. After release, requester 0 wins if both 0 and 1 are requesting.
REQ-034 Metastable input: async_req=xxxx for 100 cycles -> grant is always one-hot or zero, and never X.
